// File: rtl/ppu.sv
// Post-processing unit: collects a per-matrix max over accumulator rows, then quantizes
// each row to INT8/INT4 with a power-of-two shift and writes it to the output buffer.
`ifndef ACC_W
`define ACC_W 16
`endif
`ifndef VL
`define VL 4
`endif
`ifndef DAT_W
`define DAT_W 8
`endif
`ifndef SF_W
`define SF_W 4
`endif
`ifndef ADDR_W
`define ADDR_W 8
`endif
`ifndef AD
`define AD 8
`endif
`ifndef INT8
`define INT8 2'd0
`endif
`ifndef INT4
`define INT4 2'd1
`endif
`ifndef INT4_VSQ
`define INT4_VSQ 2'd2
`endif

module ppu #(
  parameter int ROUND_EN = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_mode,
  input  logic                       i_start,
  input  logic                       i_max_pass,
  input  logic                       i_clear,
  input  logic                       i_acc_valid,
  input  logic [`ACC_W*`VL-1:0]      i_acc_data,
  output logic                       o_wr_en,
  output logic [`ADDR_W-1:0]         o_wr_addr,
  output logic [`DAT_W*`VL-1:0]      o_wr_data,
  output logic [`SF_W-1:0]           o_sf,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int          BeatW = (`AD > 1) ? $clog2(`AD) : 1;
  localparam int unsigned SfMax = (1 << `SF_W) - 1;

  typedef enum logic [1:0] {StIdle, StMax, StCalc} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [`ACC_W-1:0]   max_q, max_d;
  logic [`ADDR_W-1:0]  tile_q, tile_d, tile_base;
  logic                last_q, last_d;
  logic                wr_en_d;
  logic [`ADDR_W-1:0]  wr_addr_d;
  logic [`DAT_W*`VL-1:0] wr_data_d;
  logic [`SF_W-1:0]    sf;

  logic signed [`ACC_W-1:0] lane_x;
  logic [`ACC_W-1:0]        lane_abs, beat_max, shift_src;
  logic signed [`ACC_W:0]   ext, rnd, shd, clip, sat_hi, sat_lo;
  int unsigned              t_m1, blen, sh;

  function automatic int unsigned bitlen(input logic [`ACC_W-1:0] v);
    bitlen = 0;
    for (int i = 0; i < `ACC_W; i++) begin
      if (v[i]) bitlen = i + 1;
    end
  endfunction

  // Magnitude of each lane; the most negative value saturates to the largest positive one.
  always_comb begin
    beat_max = '0;
    lane_x   = '0;
    lane_abs = '0;
    for (int g = 0; g < `VL; g++) begin
      lane_x = i_acc_data[g*`ACC_W +: `ACC_W];
      if (lane_x == {1'b1, {(`ACC_W-1){1'b0}}}) lane_abs = {1'b0, {(`ACC_W-1){1'b1}}};
      else if (lane_x[`ACC_W-1])                lane_abs = -lane_x;
      else                                      lane_abs = lane_x;
      if (lane_abs > beat_max) beat_max = lane_abs;
    end
  end

  always_comb begin
    t_m1      = (mode_q == `INT8) ? 32'd7 : 32'd3;
    shift_src = (mode_q == `INT4_VSQ) ? beat_max : max_q;
    blen      = bitlen(shift_src);
    sh        = (blen > t_m1) ? blen - t_m1 : 0;
    sf        = `SF_W'((sh > SfMax) ? SfMax : sh);
    sat_hi    = (`ACC_W+1)'((mode_q == `INT8) ? 127 : 7);
    sat_lo    = ~sat_hi;
    wr_data_d = '0;
    ext       = '0;
    rnd       = '0;
    shd       = '0;
    clip      = '0;
    for (int g = 0; g < `VL; g++) begin
      ext = {i_acc_data[g*`ACC_W + `ACC_W-1], i_acc_data[g*`ACC_W +: `ACC_W]};
      // One extra bit keeps the rounding add from wrapping before saturation.
      if (ROUND_EN != 0 && sf != '0) rnd = ext + ((`ACC_W+1)'(1) << (sf - 1'b1));
      else                           rnd = ext;
      shd = rnd >>> sf;
      if (shd > sat_hi)      clip = sat_hi;
      else if (shd < sat_lo) clip = sat_lo;
      else                   clip = shd;
      wr_data_d[g*`DAT_W +: `DAT_W] = clip[`DAT_W-1:0];
    end
  end

  // Clear takes effect before any update made in the same cycle.
  assign tile_base = i_clear ? '0 : tile_q;
  assign wr_addr_d = `ADDR_W'(tile_base * `AD) + `ADDR_W'(beat_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    max_d   = i_clear ? '0 : max_q;
    tile_d  = tile_base;
    last_d  = 1'b0;
    wr_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = i_max_pass ? StMax : StCalc;
          mode_d  = i_mode;
          beat_d  = '0;
        end
      end
      StMax, StCalc: begin
        if (i_acc_valid) begin
          if (state_q == StMax) begin
            if (beat_max > max_d) max_d = beat_max;
          end else begin
            wr_en_d = 1'b1;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == BeatW'(`AD - 1)) begin
            state_d = StIdle;
            beat_d  = '0;
            last_d  = 1'b1;
            if (state_q == StCalc) tile_d = tile_base + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      beat_q    <= '0;
      max_q     <= '0;
      tile_q    <= '0;
      last_q    <= 1'b0;
      o_done    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_sf      <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      max_q   <= max_d;
      tile_q  <= tile_d;
      last_q  <= last_d;
      o_done  <= last_q;
      o_wr_en <= wr_en_d;
      if (wr_en_d) begin
        o_wr_addr <= wr_addr_d;
        o_wr_data <= wr_data_d;
        o_sf      <= sf;
      end
    end
  end

  assign o_busy = (state_q != StIdle);

endmodule

// File: doc/ppu.md
PPU -- requirements
Module: ppu

Interface
REQ-001 Parameter ROUND_EN, default 1, SHALL select round-half-up before the right shift (1) or plain truncating arithmetic shift (0).
REQ-002 Widths SHALL come from define.v: `ACC_W, `VL, `DAT_W, `SF_W, `ADDR_W, `AD; mode codes SHALL be `INT8, `INT4, `INT4_VSQ.
REQ-003 i_clk  in  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 i_rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 i_mode  in  2  SHALL be the precision mode, sampled with i_start.
REQ-006 i_start  in  1  SHALL be the one-cycle pulse opening a tile pass.
REQ-007 i_max_pass  in  1  SHALL be sampled with i_start: 1 = max-collection pass, 0 = quantize pass.
REQ-008 i_clear  in  1  SHALL clear the matrix max register and the tile counter.
REQ-009 i_acc_valid  in  1  SHALL qualify i_acc_data beats.
REQ-010 i_acc_data  in  `ACC_W*`VL  SHALL carry one accumulator row of `VL signed lanes, lane g at [g*`ACC_W +: `ACC_W].
REQ-011 o_wr_en  out  1  SHALL be the output-buffer write strobe.
REQ-012 o_wr_addr  out  `ADDR_W  SHALL be the output-buffer write address.
REQ-013 o_wr_data  out  `DAT_W*`VL  SHALL carry quantized lanes, sign-extended to `DAT_W.
REQ-014 o_sf  out  `SF_W  SHALL be the shift amount applied to the current o_wr_data beat.
REQ-015 o_busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-016 o_done  out  1  SHALL pulse for one cycle when a pass completes.

Function
REQ-017 The FSM SHALL have states IDLE, MAX and CALC; on i_start in IDLE it SHALL go to MAX if i_max_pass=1, else to CALC, and latch mode; beat count SHALL reset to 0.
REQ-018 In MAX/CALC each cycle with i_acc_valid=1 SHALL consume one beat; after beat `AD-1 the FSM SHALL return to IDLE, with o_done high the following cycle.
REQ-019 i_start while busy, and i_acc_valid in IDLE, SHALL be ignored.
REQ-020 MAX: max_r SHALL become the maximum of max_r and |lane| over all lanes of each beat (|−2^(ACC_W−1)| saturated to 2^(ACC_W−1)−1); no writes.
REQ-021 Target width T SHALL be 8 for `INT8 and 4 for `INT4/`INT4_VSQ.
REQ-022 Shift SHALL be max(0, bitlen(M) − (T−1)), clamped to 2^`SF_W−1, where bitlen = index of highest set bit + 1 (bitlen(0)=0).
REQ-023 M SHALL be max_r (frozen during CALC) for `INT8/`INT4, and the max |lane| of the current beat for `INT4_VSQ.
REQ-024 Each lane SHALL be (x + 2^(s−1)) >>> s when ROUND_EN=1 and s>0, else x >>> s, then saturated to [−2^(T−1), 2^(T−1)−1].
REQ-025 CALC: a beat consumed in cycle t SHALL produce o_wr_en=1, o_wr_data, o_sf and o_wr_addr in cycle t+1 (latency 1).
REQ-026 o_wr_addr SHALL be tile_cnt*`AD + beat index; tile_cnt SHALL increment at the end of each CALC pass and wrap modulo 2^`ADDR_W.
REQ-027 i_clear SHALL zero max_r and tile_cnt; if asserted with i_start, clear SHALL apply first; i_clear during a pass SHALL not abort the pass.
REQ-028 Intermediate rounding add SHALL use `ACC_W+1 bits so no overflow occurs before saturation.

Reset
REQ-029 While i_rst_n=0 at a clock edge: state IDLE, max_r=0, tile_cnt=0, beat count=0, and o_wr_en, o_wr_addr, o_wr_data, o_sf, o_busy, o_done all 0.
REQ-030 Reset mid-pass SHALL abandon the pass with no o_done and no further writes.

Verification
REQ-031 INT8, MAX pass with a lane at 1000, then CALC with lanes 1000/−1000/1020 -> o_sf=3, outputs 125/−125/127 (saturated).
REQ-032 INT4 after MAX with max 100, CALC lane 100 -> o_sf=4, output 6; lane −200 -> −8.
REQ-033 INT4_VSQ beat with max lane 7 -> o_sf=0, lanes pass through unchanged; next beat max 30 -> o_sf=2.
REQ-034 Two CALC passes after i_clear -> addresses 0..`AD−1, then `AD..2`AD−1; o_done once per pass, one cycle after the last write beat.
REQ-035 i_acc_valid gaps mid-pass, i_start during busy, and reset at beat 3 -> no extra writes, start ignored, all outputs 0 after reset.
